// File: rtl/avl_ram_responder.sv
// avl_ram_responder
//   Avalon-MM burst responder backed by block RAM. Simulation / DDR-less
//   stand-in for a DDR3 controller local interface. Reads stream with a fixed
//   two-cycle latency; writes are absorbed beat by beat with byte enables.
//
// Ports
//   clk, reset_n              clock, async active-low reset
//   init_done                 responder ready for traffic
//   avl_ready                 command / write-beat accept
//   avl_burstbegin            first beat of burst (informational only)
//   avl_addr, avl_size        burst start word address, length in beats (0 = 1)
//   avl_read_req              read command
//   avl_write_req             write beat valid
//   avl_wdata, avl_be         write data and byte enables
//   avl_rdata_valid, avl_rdata  read beat valid and data
//
// Build option
//   AVL_RAM_RESPONDER_STALL_EN : a 16-bit LFSR pseudo-randomly drops avl_ready
//   in IDLE/WRITE to exercise initiator backpressure.
//
// state  | meaning
// S_INIT | counting INIT_CYCLES after reset, not ready
// S_IDLE | waiting for a read or write command
// S_WRITE| absorbing the remaining beats of a write burst
// S_READ | issuing one RAM read per cycle for the burst
module avl_ram_responder #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 24,
  parameter int DEPTH_LOG2  = 12,
  parameter int SIZE_WIDTH  = 7,
  parameter int INIT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  output logic                    init_done,
  output logic                    avl_ready,
  input  logic                    avl_burstbegin,
  input  logic [ADDR_WIDTH-1:0]   avl_addr,
  input  logic [SIZE_WIDTH-1:0]   avl_size,
  input  logic                    avl_read_req,
  input  logic                    avl_write_req,
  input  logic [DATA_WIDTH-1:0]   avl_wdata,
  input  logic [DATA_WIDTH/8-1:0] avl_be,
  output logic                    avl_rdata_valid,
  output logic [DATA_WIDTH-1:0]   avl_rdata
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [INIT_W-1:0]     INIT_TC  = INIT_W'(INIT_CYCLES - 1);
  localparam logic [INIT_W-1:0]     INIT_ONE = INIT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);
  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = SIZE_WIDTH'(1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WRITE, S_READ} state_e;

  state_e                  state_q, state_d;
  logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
  logic                    init_done_q, init_done_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;     // base + beat index, wraps mod depth
  logic [SIZE_WIDTH-1:0]   remaining_q, remaining_d;
  logic                    rd_pend_q;          // RAM output register holds a beat
  logic                    rdata_valid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   ram_rdata_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    stall;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic                    rd_issue;
  logic [SIZE_WIDTH-1:0]   eff_size;
  logic [DEPTH_LOG2-1:0]   cmd_addr;
  logic                    unused_ok;

  assign unused_ok = ^{avl_burstbegin, avl_addr[ADDR_WIDTH-1:DEPTH_LOG2]};
  assign cmd_addr  = avl_addr[DEPTH_LOG2-1:0];
  assign eff_size  = (avl_size == '0) ? SIZE_ONE : avl_size;

`ifdef AVL_RAM_RESPONDER_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign stall  = (lfsr_q[1:0] == 2'b00);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`else
  assign stall = 1'b0;
`endif

  assign avl_ready       = ((state_q == S_IDLE) || (state_q == S_WRITE)) && !stall;
  assign init_done       = init_done_q;
  assign avl_rdata_valid = rdata_valid_q;
  assign avl_rdata       = rdata_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    mem_we      = 1'b0;
    mem_waddr   = addr_q;
    rd_issue    = 1'b0;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_TC) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + INIT_ONE;
        end
      end
      S_IDLE: begin
        // write has priority; a simultaneous read is dropped
        if (avl_ready && avl_write_req) begin
          mem_we      = 1'b1;
          mem_waddr   = cmd_addr;
          addr_d      = cmd_addr + ADDR_ONE;
          remaining_d = eff_size - SIZE_ONE;
          if (eff_size != SIZE_ONE) state_d = S_WRITE;
        end else if (avl_ready && avl_read_req) begin
          addr_d      = cmd_addr;
          remaining_d = eff_size;
          state_d     = S_READ;
        end
      end
      S_WRITE: begin
        if (avl_ready && avl_write_req) begin
          mem_we      = 1'b1;
          addr_d      = addr_q + ADDR_ONE;
          remaining_d = remaining_q - SIZE_ONE;
          if (remaining_q == SIZE_ONE) state_d = S_IDLE;
        end
      end
      S_READ: begin
        rd_issue    = 1'b1;
        addr_d      = addr_q + ADDR_ONE;
        remaining_d = remaining_q - SIZE_ONE;
        if (remaining_q == SIZE_ONE) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      init_done_q   <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      rd_pend_q     <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      init_done_q   <= init_done_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      rd_pend_q     <= rd_issue;
      rdata_valid_q <= rd_pend_q;
      if (rd_pend_q) rdata_q <= ram_rdata_q;
    end
  end

  // RAM array and its registered read port; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (avl_be[i]) mem_q[mem_waddr][8*i +: 8] <= avl_wdata[8*i +: 8];
      end
    end
    if (rd_issue) ram_rdata_q <= mem_q[addr_q];
  end

endmodule

// File: tb/tb_avl_ram_responder.sv
module tb_avl_ram_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_done;
  logic        avl_ready;
  logic        avl_burstbegin;
  logic [23:0] avl_addr;
  logic [6:0]  avl_size;
  logic        avl_read_req;
  logic        avl_write_req;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic        avl_rdata_valid;
  logic [63:0] avl_rdata;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  logic [63:0] exp_q [0:127];

  avl_ram_responder dut (
    .clk(clk), .reset_n(reset_n), .init_done(init_done), .avl_ready(avl_ready),
    .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_wdata(avl_wdata), .avl_be(avl_be),
    .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // called at a negedge with a request driven; returns once avl_ready is seen
  task automatic wait_ready();
    int t = 0;
    while (!avl_ready && t < 200) begin
      stall_cnt++;
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_init();
    int t = 0;
    while (!init_done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("init_wait", {63'd0, init_done}, 64'd1);
  endtask

  task automatic wr_beat(input logic [23:0] a, input logic [6:0] s, input logic [63:0] d,
                         input logic [7:0] b, input bit bb, input bit rd_too);
    @(negedge clk);
    avl_write_req  = 1'b1;
    avl_read_req   = rd_too;
    avl_burstbegin = bb;
    avl_addr       = a;
    avl_size       = s;
    avl_wdata      = d;
    avl_be         = b;
    wait_ready();
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b0;
    avl_burstbegin = 1'b0;
  endtask

  // read burst; n beats expected in exp_q, checked at exact latency
  task automatic rd(input string tag, input logic [23:0] a, input logic [6:0] s,
                    input int n, input bit chk_rdy);
    @(negedge clk);
    avl_write_req  = 1'b0;
    avl_read_req   = 1'b1;
    avl_burstbegin = 1'b1;
    avl_addr       = a;
    avl_size       = s;
    wait_ready();
    @(posedge clk);
    for (int c = 0; c < n + 3; c++) begin
      @(negedge clk);
      if (c == 0) begin
        avl_read_req   = 1'b0;
        avl_burstbegin = 1'b0;
      end
      if (c >= 2 && c < n + 2) begin
        check({tag, "_vld"}, {63'd0, avl_rdata_valid}, 64'd1);
        check({tag, "_data"}, avl_rdata, exp_q[c-2]);
      end else begin
        check({tag, "_novld"}, {63'd0, avl_rdata_valid}, 64'd0);
      end
      if (chk_rdy && c < n) check({tag, "_rdy_lo"}, {63'd0, avl_ready}, 64'd0);
`ifndef AVL_RAM_RESPONDER_STALL_EN
      if (chk_rdy && c == n) check({tag, "_rdy_hi"}, {63'd0, avl_ready}, 64'd1);
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    avl_burstbegin = 1'b0;
    avl_addr       = '0;
    avl_size       = '0;
    avl_read_req   = 1'b0;
    avl_write_req  = 1'b0;
    avl_wdata      = '0;
    avl_be         = '0;
    repeat (3) @(negedge clk);
    check("rst_init_done", {63'd0, init_done}, 64'd0);
    check("rst_ready", {63'd0, avl_ready}, 64'd0);
    check("rst_vld", {63'd0, avl_rdata_valid}, 64'd0);
    check("rst_rdata", avl_rdata, 64'd0);

    // init_done exactly 16 clocks after release
    reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("init_15", {63'd0, init_done}, 64'd0);
        check("init_15_rdy", {63'd0, avl_ready}, 64'd0);
      end
      if (i == 16) begin
        check("init_16", {63'd0, init_done}, 64'd1);
`ifndef AVL_RAM_RESPONDER_STALL_EN
        check("init_16_rdy", {63'd0, avl_ready}, 64'd1);
`endif
      end
    end

    // 4-beat write with an idle gap, then immediate read-back
    wr_beat(24'h10, 7'd4, 64'h11, 8'hFF, 1'b1, 1'b0);
    wr_beat(24'h10, 7'd4, 64'h22, 8'hFF, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    wr_beat(24'h10, 7'd4, 64'h33, 8'hFF, 1'b0, 1'b0);
    wr_beat(24'h10, 7'd4, 64'h44, 8'hFF, 1'b0, 1'b0);
    exp_q[0] = 64'h11; exp_q[1] = 64'h22; exp_q[2] = 64'h33; exp_q[3] = 64'h44;
    rd("burst4", 24'h10, 7'd4, 4, 1'b1);

    // partial write with byte enables
    wr_beat(24'h20, 7'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, 1'b0);
    wr_beat(24'h20, 7'd1, 64'h0, 8'h0F, 1'b1, 1'b0);
    wr_beat(24'h20, 7'd1, 64'h0, 8'h00, 1'b1, 1'b0);
    exp_q[0] = 64'hFFFF_FFFF_0000_0000;
    rd("partial", 24'h20, 7'd1, 1, 1'b1);

    // wrap across the top of RAM
    wr_beat(24'hFFF, 7'd3, 64'hAAAA_0000_0000_000A, 8'hFF, 1'b1, 1'b0);
    wr_beat(24'hFFF, 7'd3, 64'hBBBB_0000_0000_000B, 8'hFF, 1'b0, 1'b0);
    wr_beat(24'hFFF, 7'd3, 64'hCCCC_0000_0000_000C, 8'hFF, 1'b0, 1'b0);
    exp_q[0] = 64'hBBBB_0000_0000_000B; exp_q[1] = 64'hCCCC_0000_0000_000C;
    rd("wrap_low", 24'h0, 7'd2, 2, 1'b1);
    exp_q[0] = 64'hAAAA_0000_0000_000A;
    rd("alias", 24'h1FFF, 7'd1, 1, 1'b1);
    exp_q[0] = 64'hAAAA_0000_0000_000A; exp_q[1] = 64'hBBBB_0000_0000_000B;
    exp_q[2] = 64'hCCCC_0000_0000_000C;
    rd("wrap_rd", 24'hFFF, 7'd3, 3, 1'b1);

    // simultaneous read and write: write wins, no read data
    wr_beat(24'h30, 7'd1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      check("rw_norvld", {63'd0, avl_rdata_valid}, 64'd0);
`ifndef AVL_RAM_RESPONDER_STALL_EN
      check("rw_idle_rdy", {63'd0, avl_ready}, 64'd1);
`endif
    end
    exp_q[0] = 64'hDEAD_BEEF_0123_4567;
    rd("rw_wr", 24'h30, 7'd1, 1, 1'b1);
    rd("size0", 24'h30, 7'd0, 1, 1'b1);

    // reset during the second beat of a 4-beat read
    @(negedge clk);
    avl_read_req = 1'b1;
    avl_addr     = 24'h10;
    avl_size     = 7'd4;
    wait_ready();
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) avl_read_req = 1'b0;
      if (c == 2) check("mid_b0", avl_rdata, 64'h11);
    end
    check("mid_b1_vld", {63'd0, avl_rdata_valid}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_vld", {63'd0, avl_rdata_valid}, 64'd0);
    check("mid_rst_done", {63'd0, init_done}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_hold_vld", {63'd0, avl_rdata_valid}, 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mid_post_vld", {63'd0, avl_rdata_valid}, 64'd0);
    end
    wait_init();
    exp_q[0] = 64'h11; exp_q[1] = 64'h22; exp_q[2] = 64'h33; exp_q[3] = 64'h44;
    rd("after_rst", 24'h10, 7'd4, 4, 1'b1);

`ifdef AVL_RAM_RESPONDER_STALL_EN
    // 64-beat random burst against pseudo-random backpressure
    stall_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      exp_q[i] = {$urandom, $urandom};
      wr_beat(24'h100, 7'd64, exp_q[i], 8'hFF, (i == 0), 1'b0);
    end
    rd("stall64", 24'h100, 7'd64, 64, 1'b0);
    check("stall_seen", {63'd0, (stall_cnt != 0)}, 64'd1);
`endif

    idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
